// File: rtl/niski_dbg_pkg.sv
// Shared types and defaults for the PC debug monitor.
package niski_dbg_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DELAY,
        HALTED
    } dbg_state_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular FIFO that overwrites its oldest entry when written while full,
// with a sticky overflow flag and a combinational head read port.
module trace_ring_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       pop,
    input  logic                       clr_overflow,
    output logic [XLEN-1:0]            rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            full;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[head];

    // NOTE: storage has no reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) tail <= tail + 1'b1;
            // A full write without a pop drops the oldest entry, so head moves too.
            if (do_pop || (wr_en && full)) head <= head + 1'b1;

            if (wr_en && !do_pop && !full) count <= count + 1'b1;
            else if (do_pop && !wr_en)     count <= count - 1'b1;

            if (clr_overflow)                   overflow <= 1'b0;
            else if (wr_en && full && !do_pop)  overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_trace_monitor.sv
// PC breakpoint monitor: compares retired PCs against programmable breakpoints,
// raises a sticky halt after a post-trigger delay, and traces PC changes.
module pc_trace_monitor
    import niski_dbg_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int NUM_BP      = 4,
    parameter int TRACE_DEPTH = 16,
    parameter int DELAY_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [XLEN-1:0]                pc,
    input  logic                           pc_valid,
    input  logic [NUM_BP*XLEN-1:0]         bp_addr,
    input  logic [NUM_BP-1:0]              bp_en,
    input  logic [DELAY_W-1:0]             post_delay,
    input  logic                           arm,
    input  logic                           clear,
    output logic                           halt_req,
    output logic                           triggered,
    output logic [$clog2(NUM_BP):0]        hit_idx,
    output logic [XLEN-1:0]                hit_pc,
    input  logic                           tr_pop,
    output logic [XLEN-1:0]                tr_data,
    output logic                           tr_empty,
    output logic [$clog2(TRACE_DEPTH):0]   tr_count,
    output logic                           tr_overflow
);

    localparam int IW = $clog2(NUM_BP) + 1;

    dbg_state_t        state, state_d;
    logic [DELAY_W-1:0] cnt, cnt_d;
    logic [XLEN-1:0]   last_pc;
    logic              bp_match;
    logic [IW-1:0]     bp_sel;
    logic              hit_now;
    logic              trace_wr;

    // Scan from the top so the lowest matching channel is the one left standing.
    always_comb begin
        bp_match = 1'b0;
        bp_sel   = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) begin
                bp_match = 1'b1;
                bp_sel   = IW'(i);
            end
        end
    end

    assign hit_now  = (state == ARMED) && pc_valid && bp_match;
    assign trace_wr = pc_valid && (pc != last_pc) && (state != HALTED);

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:   if (arm) state_d = ARMED;
                ARMED:  if (hit_now) begin
                            if (post_delay == '0) begin
                                state_d = HALTED;
                            end else begin
                                state_d = DELAY;
                                cnt_d   = post_delay;
                            end
                        end
                DELAY:  if (cnt == DELAY_W'(1)) state_d = HALTED;
                        else                    cnt_d   = cnt - 1'b1;
                HALTED: state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hit_idx <= '0;
            hit_pc  <= '0;
            last_pc <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (clear) begin
                hit_idx <= '0;
                hit_pc  <= '0;
            end else if (hit_now) begin
                hit_idx <= bp_sel;
                hit_pc  <= pc;
            end
            if (trace_wr) last_pc <= pc;
        end
    end

    assign halt_req  = (state == HALTED);
    assign triggered = (state == DELAY) || (state == HALTED);

    trace_ring_buffer #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (trace_wr),
        .wr_data      (pc),
        .pop          (tr_pop),
        .clr_overflow (clear),
        .rd_data      (tr_data),
        .empty        (tr_empty),
        .count        (tr_count),
        .overflow     (tr_overflow)
    );

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor with a queue scoreboard for the trace buffer.
module tb_pc_trace_monitor;

    localparam int XLEN   = 32;
    localparam int NUM_BP = 4;
    localparam int DEPTH  = 16;
    localparam int DW     = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [XLEN-1:0]          pc;
    logic                     pc_valid;
    logic [NUM_BP*XLEN-1:0]   bp_addr;
    logic [NUM_BP-1:0]        bp_en;
    logic [DW-1:0]            post_delay;
    logic                     arm;
    logic                     clear;
    logic                     halt_req;
    logic                     triggered;
    logic [2:0]               hit_idx;
    logic [XLEN-1:0]          hit_pc;
    logic                     tr_pop;
    logic [XLEN-1:0]          tr_data;
    logic                     tr_empty;
    logic [4:0]               tr_count;
    logic                     tr_overflow;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Trace model state
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] m_last;
    logic            m_ovf;
    logic            m_halted;

    always #5 clk = ~clk;

    pc_trace_monitor #(
        .XLEN(XLEN), .NUM_BP(NUM_BP), .TRACE_DEPTH(DEPTH), .DELAY_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid),
        .bp_addr(bp_addr), .bp_en(bp_en), .post_delay(post_delay),
        .arm(arm), .clear(clear), .halt_req(halt_req), .triggered(triggered),
        .hit_idx(hit_idx), .hit_pc(hit_pc), .tr_pop(tr_pop), .tr_data(tr_data),
        .tr_empty(tr_empty), .tr_count(tr_count), .tr_overflow(tr_overflow)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_trace(input string tag);
        check({tag, ".count"}, 32'(tr_count), 32'(exp_q.size()));
        check({tag, ".empty"}, 32'(tr_empty), 32'(exp_q.size() == 0));
        check({tag, ".ovf"},   32'(tr_overflow), 32'(m_ovf));
        check({tag, ".head"},  tr_data, (exp_q.size() == 0) ? '0 : exp_q[0]);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last   = '0;
        m_ovf    = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock: drive pc/valid/pop, update model, advance past the edge.
    task automatic tick(input logic [XLEN-1:0] p, input logic v, input logic pp);
        pc       = p;
        pc_valid = v;
        tr_pop   = pp;
        if (pp && exp_q.size() > 0) begin
            check("pop_data", tr_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (v && (p != m_last) && !m_halted) begin
            exp_q.push_back(p);
            m_last = p;
            if (exp_q.size() > DEPTH) begin
                void'(exp_q.pop_front());
                m_ovf = 1'b1;
            end
        end
        if (clear) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        arm      = 1'b0;
        clear    = 1'b0;
        pc_valid = 1'b0;
        tr_pop   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick('0, 1'b0, 1'b0);
        m_halted = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) tick('0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; pc_valid = 1'b0; bp_addr = '0; bp_en = '0;
        post_delay = '0; arm = 1'b0; clear = 1'b0; tr_pop = 1'b0;
        model_reset();
        #3;
        check("rst.halt", 32'(halt_req), 0);
        check("rst.trig", 32'(triggered), 0);
        check("rst.idx",  32'(hit_idx), 0);
        check("rst.hpc",  hit_pc, 0);
        check_trace("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1) single breakpoint, zero delay
        bp_addr[0*XLEN +: XLEN] = 32'h4000_144C;
        bp_en = 4'b0001; post_delay = '0;
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h4000_1448, 1'b1, 1'b0);
        check("t1.pre_halt", 32'(halt_req), 0);
        tick(32'h4000_144C, 1'b1, 1'b0);
        m_halted = 1'b1;
        check("t1.halt", 32'(halt_req), 1);
        check("t1.trig", 32'(triggered), 1);
        check("t1.idx",  32'(hit_idx), 0);
        check("t1.hpc",  hit_pc, 32'h4000_144C);
        tick(32'h4000_1450, 1'b1, 1'b0);
        check("t1.sticky", 32'(halt_req), 1);
        check_trace("t1");
        do_clear();
        check("t1.clr_halt", 32'(halt_req), 0);
        check("t1.clr_hpc",  hit_pc, 0);

        // 2) priority among channels
        bp_addr[0*XLEN +: XLEN] = 32'h4000_0010;
        bp_addr[2*XLEN +: XLEN] = 32'h4000_0010;
        bp_en = 4'b0101;
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h4000_0010, 1'b1, 1'b0);
        m_halted = 1'b1;
        check("t2.idx0", 32'(hit_idx), 0);
        do_clear();
        bp_en = 4'b0100;
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h4000_0010, 1'b1, 1'b0);
        m_halted = 1'b1;
        check("t2.idx2", 32'(hit_idx), 2);
        check("t2.hpc",  hit_pc, 32'h4000_0010);
        do_clear();
        // clear beats a same-cycle arm
        arm = 1'b1; clear = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h4000_0010, 1'b1, 1'b0);
        check("t2.clr_wins", 32'(triggered), 0);

        // 3) post-trigger delay of 5
        bp_en = 4'b0001; post_delay = 16'd5;
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h4000_0010, 1'b1, 1'b0);            // hit at N; now in N+1
        check("t3.trig_n1", 32'(triggered), 1);
        check("t3.halt_n1", 32'(halt_req), 0);
        tick(32'h0000_0200, 1'b1, 1'b0);            // traced while delaying
        for (int k = 2; k < 5; k++) begin
            check("t3.halt_early", 32'(halt_req), 0);
            tick('0, 1'b0, 1'b0);
        end
        check("t3.halt_n5", 32'(halt_req), 0);
        tick('0, 1'b0, 1'b0);
        m_halted = 1'b1;
        check("t3.halt_n6", 32'(halt_req), 1);
        do_clear();
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h4000_0010, 1'b1, 1'b0);            // N+1
        tick('0, 1'b0, 1'b0);                       // N+2
        clear = 1'b1; tick('0, 1'b0, 1'b0);         // clear at N+3
        for (int k = 0; k < 6; k++) begin
            check("t3.no_halt", 32'(halt_req), 0);
            tick('0, 1'b0, 1'b0);
        end
        check("t3.idle_trig", 32'(triggered), 0);

        // 4) overflow of the trace buffer
        drain();
        check_trace("t4.drained");
        for (int i = 0; i < 20; i++) tick(32'h100 + 32'(i) * 4, 1'b1, 1'b0);
        check("t4.count", 32'(tr_count), 16);
        check("t4.ovf",   32'(tr_overflow), 1);
        check("t4.first", tr_data, 32'h110);
        check_trace("t4.full");
        drain();
        check("t4.empty", 32'(tr_empty), 1);
        check("t4.ovf_sticky", 32'(tr_overflow), 1);
        do_clear();
        check("t4.ovf_clr", 32'(tr_overflow), 0);

        // 5) repeated PC traced once; nothing traced while halted
        for (int i = 0; i < 10; i++) tick(32'h300, 1'b1, 1'b0);
        check("t5.once", 32'(tr_count), 1);
        bp_addr[0*XLEN +: XLEN] = 32'h304; post_delay = '0;
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h304, 1'b1, 1'b0);
        m_halted = 1'b1;
        tick(32'h308, 1'b1, 1'b0);
        tick(32'h30C, 1'b1, 1'b0);
        check("t5.frozen", 32'(tr_count), 2);
        check_trace("t5");
        do_clear();
        drain();

        // 6) pop + write while full, then reset mid-delay
        for (int i = 0; i < 16; i++) tick(32'h500 + 32'(i) * 4, 1'b1, 1'b0);
        check_trace("t6.full");
        tick(32'h600, 1'b1, 1'b1);
        check("t6.count", 32'(tr_count), 16);
        check("t6.no_ovf", 32'(tr_overflow), 0);
        check_trace("t6.pw");
        bp_addr[0*XLEN +: XLEN] = 32'h700; post_delay = 16'd5;
        arm = 1'b1; tick('0, 1'b0, 1'b0);
        tick(32'h700, 1'b1, 1'b0);
        tick('0, 1'b0, 1'b0);
        check("t6.in_delay", 32'(triggered), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6.rst_trig", 32'(triggered), 0);
        check("t6.rst_halt", 32'(halt_req), 0);
        check("t6.rst_idx",  32'(hit_idx), 0);
        check("t6.rst_hpc",  hit_pc, 0);
        check_trace("t6.rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
